// File: rtl/imm_decode_stage.sv
// Decode stage ahead of execute: derives ImmSel from opcode/funct3, generates the immediate
// with imm_gen on instr[31:7], and hands entries to execute through a 2-entry skid buffer.

module imm_gen #(
  parameter int DWIDTH   = 32,
  parameter int IMMWIDTH = 25
) (
  input  logic [IMMWIDTH-1:0] imm_in,
  input  logic [3:0]          imm_sel,
  output logic [DWIDTH-1:0]   imm_out
);

  // Re-index so that ins[k] lines up with instruction bit k (imm_in starts at bit 7).
  logic [31:0] ins;
  logic [31:0] imm32;

  assign ins = {imm_in[24:0], 7'b0000000};

  // Immediate format selection; codes outside the defined set produce zero.
  always_comb begin
    imm32 = 32'h0000_0000;
    case (imm_sel)
      4'b1000: imm32 = {{20{ins[31]}}, ins[31:20]};
      4'b0000: imm32 = {27'h000_0000, ins[24:20]};
      4'b0001: imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      4'b0010: imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      4'b0011: imm32 = {ins[31:12], 12'h000};
      4'b0100: imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm32 = 32'h0000_0000;
    endcase
  end

  assign imm_out = DWIDTH'($signed(imm32));

endmodule

module imm_decode_stage #(
  parameter int DWIDTH   = 32,
  parameter int IMMWIDTH = 25,
  parameter int PCWIDTH  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [PCWIDTH-1:0] in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DWIDTH-1:0]  out_imm,
  output logic [3:0]         out_immsel,
  output logic [PCWIDTH-1:0] out_pc,
  output logic               out_illegal
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DWIDTH-1:0]  imm;
    logic [3:0]         immsel;
    logic [PCWIDTH-1:0] pc;
    logic               illegal;
  } entry_t;

  localparam entry_t RST_ENTRY = '{imm: '0, immsel: 4'b0111, pc: '0, illegal: 1'b0};

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [3:0]        immsel_s;
  logic              illegal_s;
  logic [DWIDTH-1:0] imm_s;
  logic              in_fire;
  logic              out_fire;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];

  // ImmSel and legality decode from opcode/funct3.
  always_comb begin
    immsel_s  = 4'b0111;
    illegal_s = 1'b0;
    case (opcode)
      7'b0000011, 7'b1100111: immsel_s = 4'b1000;
      7'b0010011: begin
        if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
          immsel_s = 4'b0000;
        end else begin
          immsel_s = 4'b1000;
        end
      end
      7'b0100011:             immsel_s = 4'b0001;
      7'b1100011:             immsel_s = 4'b0010;
      7'b0110111, 7'b0010111: immsel_s = 4'b0011;
      7'b1101111:             immsel_s = 4'b0100;
      7'b0110011:             immsel_s = 4'b0111;
      default: begin
        immsel_s  = 4'b0111;
        illegal_s = 1'b1;
      end
    endcase
  end

  imm_gen #(
    .DWIDTH   (DWIDTH),
    .IMMWIDTH (IMMWIDTH)
  ) u_imm_gen (
    .imm_in  (in_instr[31:7]),
    .imm_sel (immsel_s),
    .imm_out (imm_s)
  );

  assign in_entry = '{imm: imm_s, immsel: immsel_s, pc: in_pc, illegal: illegal_s};

  assign in_ready    = (state_q != FULL);
  assign out_valid   = (state_q != EMPTY);
  assign in_fire     = in_valid & in_ready;
  assign out_fire    = out_valid & out_ready;
  assign out_imm     = main_q.imm;
  assign out_immsel  = main_q.immsel;
  assign out_pc      = main_q.pc;
  assign out_illegal = main_q.illegal;

  // Occupancy FSM; MAIN keeps its contents when it empties so outputs hold their last value.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_entry;
            state_d = HALF;
          end else begin
            state_d = EMPTY;
          end
        end
        HALF: begin
          if (in_fire && out_fire) begin
            main_d  = in_entry;
            state_d = HALF;
          end else if (in_fire) begin
            skid_d  = in_entry;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end else begin
            state_d = HALF;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = HALF;
          end else begin
            state_d = FULL;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = RST_ENTRY;
          skid_d  = '0;
        end
      endcase
    end
  end

  // State and entry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= RST_ENTRY;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule
